// File: rtl/add_seq_fsm.sv
// add_seq_fsm: bit-serial add/subtract word-line sequencer for the compute-in-memory array
module add_seq_fsm #(
  parameter int ROWS = 16,
  parameter int AW = $clog2(ROWS),
  parameter int MAX_BITS = 8,
  parameter int NW = $clog2(MAX_BITS + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            sub,
  input  logic            keep_carry,
  input  logic [NW-1:0]   nbits,
  input  logic [AW-1:0]   a_base,
  input  logic [AW-1:0]   b_base,
  input  logic [AW-1:0]   p_base,
  output logic [ROWS-1:0] RWLv1,
  output logic [ROWS-1:0] RWLv2,
  output logic [ROWS-1:0] WWLp,
  output logic            CLR,
  output logic            CIN,
  output logic            C_EN,
  output logic            INV_B,
  output logic            busy,
  output logic            DONE,
  output logic            err
);
  localparam int SW = AW + NW + 1;
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_READ, S_WRITE, S_CARRY, S_DONE, S_ERR} state_t;
  state_t state, state_n;
  logic [NW-1:0] i_r, i_n, nb_r, nb_n;
  logic [AW-1:0] a_r, a_n, b_r, b_n, p_r, p_n;
  logic sub_r, sub_n, kc_r, kc_n, legal, last, rd;
  logic [ROWS-1:0] rwl1_n, rwl2_n, wwl_n;
  logic clr_n, cin_n, cen_n, invb_n, busy_n, done_n, err_n;
  function automatic logic [ROWS-1:0] onehot(input logic [SW-1:0] idx);
    return ROWS'(1) << idx;
  endfunction
  // request range check on the live inputs, widened so base+nbits never wraps
  always_comb begin
    legal = nbits != '0 && nbits <= NW'(MAX_BITS)
         && SW'(a_base) + SW'(nbits) <= SW'(ROWS)
         && SW'(b_base) + SW'(nbits) <= SW'(ROWS)
         && SW'(p_base) + SW'(nbits) + SW'(keep_carry) <= SW'(ROWS);
  end
  // next state, bit counter and operand capture
  always_comb begin
    state_n = state;
    i_n = i_r;
    nb_n = nb_r;
    a_n = a_r;
    b_n = b_r;
    p_n = p_r;
    sub_n = sub_r;
    kc_n = kc_r;
    last = i_r == nb_r - NW'(1);
    case (state)
      S_IDLE: if (start) begin
        state_n = legal ? S_CLR : S_ERR;
        i_n = '0;
        nb_n = nbits;
        a_n = a_base;
        b_n = b_base;
        p_n = p_base;
        sub_n = sub;
        kc_n = keep_carry;
      end
      S_CLR: begin
        state_n = S_READ;
        i_n = '0;
      end
      S_READ: state_n = S_WRITE;
      S_WRITE: begin
        state_n = last ? (kc_r ? S_CARRY : S_DONE) : S_READ;
        i_n = last ? i_r : i_r + NW'(1);
      end
      S_CARRY: state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end
  // outputs for the coming cycle, decoded from the next state so they can be registered
  always_comb begin
    rd = state_n == S_READ || state_n == S_WRITE;
    rwl1_n = rd ? onehot(SW'(a_n) + SW'(i_n)) : '0;
    rwl2_n = rd ? onehot(SW'(b_n) + SW'(i_n)) : '0;
    wwl_n = state_n == S_WRITE ? onehot(SW'(p_n) + SW'(i_n)) :
            state_n == S_CARRY ? onehot(SW'(p_n) + SW'(nb_n)) : '0;
    clr_n = state_n == S_CLR;
    cin_n = clr_n & sub_n;
    cen_n = state_n == S_WRITE;
    invb_n = sub_n & (state_n inside {S_CLR, S_READ, S_WRITE, S_CARRY});
    busy_n = state_n != S_IDLE;
    done_n = state_n == S_DONE || state_n == S_ERR;
    err_n = state_n == S_ERR;
  end
  // state, captured request and registered glitch-free outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      i_r <= '0;
      nb_r <= '0;
      a_r <= '0;
      b_r <= '0;
      p_r <= '0;
      sub_r <= 1'b0;
      kc_r <= 1'b0;
      RWLv1 <= '0;
      RWLv2 <= '0;
      WWLp <= '0;
      CLR <= 1'b0;
      CIN <= 1'b0;
      C_EN <= 1'b0;
      INV_B <= 1'b0;
      busy <= 1'b0;
      DONE <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      i_r <= i_n;
      nb_r <= nb_n;
      a_r <= a_n;
      b_r <= b_n;
      p_r <= p_n;
      sub_r <= sub_n;
      kc_r <= kc_n;
      RWLv1 <= rwl1_n;
      RWLv2 <= rwl2_n;
      WWLp <= wwl_n;
      CLR <= clr_n;
      CIN <= cin_n;
      C_EN <= cen_n;
      INV_B <= invb_n;
      busy <= busy_n;
      DONE <= done_n;
      err <= err_n;
    end
  end
endmodule

// File: tb/tb_add_seq_fsm.sv
// tb_add_seq_fsm: schedule-based reference check of add_seq_fsm
module tb_add_seq_fsm;
  localparam int ROWS = 16;
  localparam int AW = 4;
  localparam int MAX_BITS = 8;
  localparam int NW = 4;
  typedef struct packed {
    logic [ROWS-1:0] rwl1, rwl2, wwl;
    logic clr, cin, cen, invb, busy, done, err;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0, keep_carry = 1'b0;
  logic [NW-1:0] nbits = '0;
  logic [AW-1:0] a_base = '0, b_base = '0, p_base = '0;
  logic [ROWS-1:0] RWLv1, RWLv2, WWLp;
  logic CLR, CIN, C_EN, INV_B, busy, DONE, err;
  int tests = 0, fails = 0, done_cnt;
  string tag = "reset";
  exp_t exp_v = '0;
  exp_t q[$];
  add_seq_fsm #(.ROWS(ROWS), .MAX_BITS(MAX_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .keep_carry(keep_carry),
    .nbits(nbits), .a_base(a_base), .b_base(b_base), .p_base(p_base),
    .RWLv1(RWLv1), .RWLv2(RWLv2), .WWLp(WWLp), .CLR(CLR), .CIN(CIN), .C_EN(C_EN),
    .INV_B(INV_B), .busy(busy), .DONE(DONE), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string t, input logic [63:0] obs, input logic [63:0] want);
    tests++;
    if (obs !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", t, obs, want);
    end
  endtask
  // expected per-cycle output list for a request, from the timing rules
  task automatic build();
    int n = int'(nbits), a = int'(a_base), b = int'(b_base), p = int'(p_base), k = int'(keep_carry);
    exp_t e;
    if (n < 1 || n > MAX_BITS || a + n - 1 >= ROWS || b + n - 1 >= ROWS || p + n - 1 + k >= ROWS) begin
      e = '0; e.busy = 1; e.done = 1; e.err = 1; q.push_back(e);
      return;
    end
    e = '0; e.busy = 1; e.clr = 1; e.cin = sub; e.invb = sub; q.push_back(e);
    for (int i = 0; i < n; i++) begin
      e = '0; e.busy = 1; e.invb = sub;
      e.rwl1 = ROWS'(1) << (a + i); e.rwl2 = ROWS'(1) << (b + i);
      q.push_back(e);
      e.wwl = ROWS'(1) << (p + i); e.cen = 1;
      q.push_back(e);
    end
    if (k != 0) begin
      e = '0; e.busy = 1; e.invb = sub; e.wwl = ROWS'(1) << (p + n); q.push_back(e);
    end
    e = '0; e.busy = 1; e.done = 1; q.push_back(e);
  endtask
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      exp_v = '0;
    end else begin
      if (!exp_v.busy && start) build();
      if (q.size() > 0) exp_v = q.pop_front();
      else exp_v = '0;
    end
    @(negedge clk);
    if (DONE) done_cnt++;
    check(tag, 64'({RWLv1, RWLv2, WWLp, CLR, CIN, C_EN, INV_B, busy, DONE, err}), 64'(exp_v));
  endtask
  task automatic junk();
    start = 1'($urandom); sub = 1'($urandom); keep_carry = 1'($urandom);
    nbits = NW'($urandom); a_base = AW'($urandom); b_base = AW'($urandom); p_base = AW'($urandom);
  endtask
  task automatic go(input string t, input logic s, input logic k, input int n, input int a, input int b, input int p);
    tag = t;
    start = 1; sub = s; keep_carry = k; nbits = NW'(n); a_base = AW'(a); b_base = AW'(b); p_base = AW'(p);
    step();
    for (int c = 0; c < 40 && exp_v.busy; c++) begin
      junk();
      step();
    end
    if (exp_v.busy) check({t, "_timeout"}, 1, 0);
    start = 0;
  endtask
  initial begin
    step();
    step();
    rst_n = 1;
    step();
    go("add4", 0, 0, 4, 0, 4, 8);
    go("sub4_kc", 1, 1, 4, 0, 4, 8);
    go("top_p13", 0, 0, 4, 0, 4, 13);
    go("top_p13_kc", 0, 1, 4, 0, 4, 13);
    go("nbits0", 0, 0, 0, 0, 4, 8);
    go("nbits_max1", 1, 0, MAX_BITS + 1, 0, 0, 0);
    go("max_bits", 1, 1, MAX_BITS, 8, 0, 7);
    go("inplace", 0, 0, 3, 5, 5, 5);
    go("a_over", 0, 0, 4, 13, 0, 0);
    tag = "continuous";
    done_cnt = 0;
    start = 1; sub = 0; keep_carry = 0; nbits = 1; a_base = 0; b_base = 0; p_base = 0;
    for (int c = 0; c < 50; c++) step();
    check("cont_done_count", 64'(done_cnt), 10);
    start = 0;
    for (int c = 0; c < 10 && exp_v.busy; c++) step();
    tag = "mid_reset";
    start = 1; nbits = 4; a_base = 0; b_base = 4; p_base = 8;
    step();
    start = 0;
    for (int c = 0; c < 6; c++) step();
    check("in_write2", 64'(WWLp), 64'(16'h0400));
    rst_n = 0;
    step();
    rst_n = 1;
    step();
    go("after_reset", 0, 0, 4, 0, 4, 8);
    for (int r = 0; r < 60; r++) begin
      int n = $urandom_range(0, MAX_BITS + 1);
      int hi = (n >= 1 && n <= ROWS) ? ROWS - n : ROWS - 1;
      if ($urandom_range(0, 3) == 0)
        go("rand", 1'($urandom), 1'($urandom), n, $urandom_range(0, ROWS - 1), $urandom_range(0, ROWS - 1), $urandom_range(0, ROWS - 1));
      else
        go("rand", 1'($urandom), 1'($urandom), n, $urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi));
      if ($urandom_range(0, 1) == 1) step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
